// File: rtl/dpll_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg
// Types and constants shared by the DPLL blocks: controller state encoding,
// the loop-filter K-code width and its legal code range, and the activity
// counter width with its saturating increment helper.
// ---------------------------------------------------------------------------
package dpll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_OBSERVE = 2'd2
    } dpll_state_t;

    localparam int KMODE_W = 4;

    // Legal K-code range of the loop filter.
    localparam logic [KMODE_W-1:0] K_CODE_LO = 4'd1;
    localparam logic [KMODE_W-1:0] K_CODE_HI = 4'd15;

    // Carry/borrow activity counter width (saturates at all-ones).
    localparam int ACT_W = 8;

    function automatic logic [ACT_W-1:0] sat_inc(input logic [ACT_W-1:0] v,
                                                 input logic             inc);
        logic [ACT_W-1:0] r;
        r = v;
        if (inc && (v != '1)) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dlf_gear_ctrl_if.sv
// ---------------------------------------------------------------------------
// dlf_gear_ctrl_if
// Bundle between the gear controller, the loop filter and top-level control.
//   start, stop      : acquisition control from top-level DPLL control
//   carry, borrow    : loop-filter overflow/underflow pulses
//   kMode            : modulus select to the loop filter
//   dlf_enable       : loop-filter enable
//   locked, busy     : status back to top-level control
// master = the gear controller, slave = its environment.
// ---------------------------------------------------------------------------
interface dlf_gear_ctrl_if;

    logic                          start;
    logic                          stop;
    logic                          carry;
    logic                          borrow;
    logic [dpll_pkg::KMODE_W-1:0]  kMode;
    logic                          dlf_enable;
    logic                          locked;
    logic                          busy;

    modport master (
        input  start, stop, carry, borrow,
        output kMode, dlf_enable, locked, busy
    );

    modport slave (
        output start, stop, carry, borrow,
        input  kMode, dlf_enable, locked, busy
    );

endinterface

// File: rtl/dlf_act_window.sv
// ---------------------------------------------------------------------------
// dlf_act_window
// Observation window timer plus saturating activity counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero both counters (priority over enable)
//   enable     : window running
//   pulse      : one activity event this cycle
//   win_end    : this cycle is the last of the window
//   act_total  : activity count including this cycle's pulse, so the value
//                seen alongside win_end is the complete window total
// The window restarts by itself after win_end.
// ---------------------------------------------------------------------------
module dlf_act_window
    import dpll_pkg::*;
#(
    parameter int WIN_LEN = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             pulse,
    output logic             win_end,
    output logic [ACT_W-1:0] act_total
);

    localparam int WW = $clog2(WIN_LEN);

    logic [WW-1:0]    win_cnt_reg;
    logic [ACT_W-1:0] act_cnt_reg;

    assign win_end   = enable && (win_cnt_reg == WW'(WIN_LEN - 1));
    assign act_total = sat_inc(act_cnt_reg, pulse);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            win_cnt_reg <= '0;
            act_cnt_reg <= '0;
        end else if (enable) begin
            if (win_end) begin
                win_cnt_reg <= '0;
                act_cnt_reg <= '0;
            end else begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                act_cnt_reg <= act_total;
            end
        end
    end

endmodule

// File: rtl/dlf_gear_ctrl.sv
// ---------------------------------------------------------------------------
// dlf_gear_ctrl
// Adaptive K-mode controller for the DPLL loop filter. Counts carry/borrow
// activity over fixed windows; busy windows shift K down (fast acquisition),
// quiet windows shift K up (low jitter); LOCK_WINS consecutive quiet windows
// at K_MAX assert locked. Every K change passes through SETTLE with the filter
// disabled, so the filter never sees a modulus change while running.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : dlf_gear_ctrl_if.master (start/stop/carry/borrow in;
//           kMode/dlf_enable/locked/busy out, all registered)
// ---------------------------------------------------------------------------
module dlf_gear_ctrl
    import dpll_pkg::*;
#(
    parameter int WIN_LEN    = 1024,
    parameter int SETTLE_CYC = 4,
    parameter int K_MIN      = 1,
    parameter int K_MAX      = 14,
    parameter int LO_THR     = 2,
    parameter int HI_THR     = 16,
    parameter int LOCK_WINS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    dlf_gear_ctrl_if.master bus
);

    // K limits clamped into the filter's legal code range.
    localparam logic [KMODE_W-1:0] K_MIN_C =
        (KMODE_W'(K_MIN) < K_CODE_LO) ? K_CODE_LO : KMODE_W'(K_MIN);
    localparam logic [KMODE_W-1:0] K_MAX_C =
        (KMODE_W'(K_MAX) > K_CODE_HI) ? K_CODE_HI : KMODE_W'(K_MAX);

    localparam logic [ACT_W-1:0] LO_C   = ACT_W'(LO_THR);
    localparam logic [ACT_W-1:0] HI_C   = ACT_W'(HI_THR);
    localparam logic [7:0]       LOCK_C = 8'(LOCK_WINS);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    dpll_state_t        state_reg, state_next;
    logic [KMODE_W-1:0] kmode_reg, kmode_next;
    logic               locked_reg, locked_next;
    logic [7:0]         quiet_reg, quiet_next;
    logic [SW-1:0]      settle_reg, settle_next;
    logic               dlf_enable_reg;
    logic               busy_reg;

    logic               win_clear;
    logic               win_end;
    logic [ACT_W-1:0]   act_total;
    logic [7:0]         quiet_inc;

    // Activity is counted only while observing; the window is held clear
    // in every other state.
    dlf_act_window #(
        .WIN_LEN (WIN_LEN)
    ) u_win (
        .clk       (clk),
        .reset     (reset),
        .clear     (win_clear),
        .enable    (state_reg == ST_OBSERVE),
        .pulse     (bus.carry | bus.borrow),
        .win_end   (win_end),
        .act_total (act_total)
    );

    assign quiet_inc = (quiet_reg < LOCK_C) ? (quiet_reg + 8'd1) : quiet_reg;

    always_comb begin
        state_next  = state_reg;
        kmode_next  = kmode_reg;
        locked_next = locked_reg;
        quiet_next  = quiet_reg;
        settle_next = settle_reg;
        win_clear   = 1'b0;

        if (bus.stop) begin
            // Abort: K is kept so a later restart is visible on kMode only
            // once start reloads K_MIN.
            state_next  = ST_IDLE;
            locked_next = 1'b0;
            quiet_next  = '0;
            settle_next = '0;
            win_clear   = 1'b1;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    win_clear = 1'b1;
                    if (bus.start) begin
                        state_next  = ST_SETTLE;
                        kmode_next  = K_MIN_C;
                        settle_next = '0;
                        quiet_next  = '0;
                        locked_next = 1'b0;
                    end
                end

                ST_SETTLE: begin
                    win_clear = 1'b1;
                    if (settle_reg == SETTLE_LAST) begin
                        state_next  = ST_OBSERVE;
                        settle_next = '0;
                    end else begin
                        settle_next = settle_reg + 1'b1;
                    end
                end

                ST_OBSERVE: begin
                    if (win_end) begin
                        if (act_total > HI_C) begin
                            quiet_next  = '0;
                            locked_next = 1'b0;
                            if (kmode_reg > K_MIN_C) begin
                                kmode_next = kmode_reg - 1'b1;
                                state_next = ST_SETTLE;
                            end
                        end else if (act_total < LO_C) begin
                            if (kmode_reg < K_MAX_C) begin
                                kmode_next = kmode_reg + 1'b1;
                                quiet_next = '0;
                                state_next = ST_SETTLE;
                            end else begin
                                quiet_next = quiet_inc;
                                if (quiet_inc == LOCK_C) begin
                                    locked_next = 1'b1;
                                end
                            end
                        end else begin
                            quiet_next = '0;
                        end
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    win_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            kmode_reg      <= K_MIN_C;
            locked_reg     <= 1'b0;
            quiet_reg      <= '0;
            settle_reg     <= '0;
            dlf_enable_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            kmode_reg      <= kmode_next;
            locked_reg     <= locked_next;
            quiet_reg      <= quiet_next;
            settle_reg     <= settle_next;
            // Status flags follow the state being entered so they stay
            // aligned with state_reg.
            dlf_enable_reg <= (state_next == ST_OBSERVE);
            busy_reg       <= (state_next != ST_IDLE);
        end
    end

    assign bus.kMode      = kmode_reg;
    assign bus.dlf_enable = dlf_enable_reg;
    assign bus.locked     = locked_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_dlf_gear_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dlf_gear_ctrl
// Directed scenario for dlf_gear_ctrl (WIN_LEN=16, SETTLE_CYC=4, K 1..14,
// LO_THR=2, HI_THR=6, LOCK_WINS=3). Every change of the output tuple
// {kMode, dlf_enable, locked, busy} must match, in order, an expected entry
// with the cycle at which it appears. Cycle N = after the Nth rising edge.
// ---------------------------------------------------------------------------
module tb_dlf_gear_ctrl;
    import dpll_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dlf_gear_ctrl_if bus();

    dlf_gear_ctrl #(
        .WIN_LEN    (16),
        .SETTLE_CYC (4),
        .K_MIN      (1),
        .K_MAX      (14),
        .LO_THR     (2),
        .HI_THR     (6),
        .LOCK_WINS  (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] k;
        logic       en;
        logic       lk;
        logic       bz;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         mon_en = 1'b0;
    logic [6:0] prev;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output change pops one expectation.
    always @(negedge clk) begin
        logic [6:0] cur;
        exp_t       e;
        if (mon_en) begin
            cur = {bus.kMode, bus.dlf_enable, bus.locked, bus.busy};
            if (cur !== prev) begin
                prev = cur;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc %0d got kMode=%0d en=%0b locked=%0b busy=%0b, required no change",
                             cyc, cur[6:3], cur[2], cur[1], cur[0]);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc != cyc) || (cur !== {e.k, e.en, e.lk, e.bz})) begin
                        miscompares++;
                        $display("FAIL out_tuple cyc %0d got kMode=%0d en=%0b locked=%0b busy=%0b, required cyc %0d kMode=%0d en=%0b locked=%0b busy=%0b",
                                 cyc, cur[6:3], cur[2], cur[1], cur[0],
                                 e.cyc, e.k, e.en, e.lk, e.bz);
                    end else begin
                        $display("vec %0d cyc %0d kMode=%0d en=%0b locked=%0b busy=%0b ok",
                                 vectors, cyc, cur[6:3], cur[2], cur[1], cur[0]);
                    end
                end
            end
        end
    end

    task automatic expect_out(input int c, input int k, input bit en,
                              input bit lk, input bit bz);
        exp_t e;
        e.cyc = c;
        e.k   = 4'(k);
        e.en  = en;
        e.lk  = lk;
        e.bz  = bz;
        exp_q.push_back(e);
    endtask

    // Return 1 time unit after rising edge t; inputs set now are sampled at t+1.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses sampled on edges first .. first+n-1.
    task automatic pulses(input int first, input int n, input bit both);
        goto(first - 1);
        bus.carry  = 1'b1;
        bus.borrow = both;
        goto(first + n - 1);
        bus.carry  = 1'b0;
        bus.borrow = 1'b0;
    endtask

    initial begin
        int e_c;
        int s_c;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.carry  = 1'b0;
        bus.borrow = 1'b0;
        prev       = 'x;

        goto(1);
        expect_out(1, 1, 0, 0, 0);          // reset state
        mon_en = 1'b1;
        goto(3);
        reset = 1'b0;

        e_c = cyc + 1;                      // start sampled on edge e_c
        s_c = e_c + 530;                    // second start edge

        // Acquisition from K=1 to K=14 with no activity, then lock.
        expect_out(e_c,     1, 0, 0, 1);
        expect_out(e_c + 4, 1, 1, 0, 1);
        for (int k = 2; k <= 14; k++) begin
            expect_out(e_c + 20*(k-1),     k, 0, 0, 1);
            expect_out(e_c + 20*(k-1) + 4, k, 1, 0, 1);
        end
        expect_out(e_c + 312, 14, 1, 1, 1);
        // 8 pulses: shift down, then a quiet window shifts back up.
        expect_out(e_c + 328, 13, 0, 0, 1);
        expect_out(e_c + 332, 13, 1, 0, 1);
        expect_out(e_c + 348, 14, 0, 0, 1);
        expect_out(e_c + 352, 14, 1, 0, 1);
        // quiet, quiet, 2-pulse, quiet x3 -> lock only after the last three.
        expect_out(e_c + 448, 14, 1, 1, 1);
        // 7 carry+borrow cycles -> busy.
        expect_out(e_c + 464, 13, 0, 0, 1);
        expect_out(e_c + 468, 13, 1, 0, 1);
        // 6 pulses + 1 on the window-end cycle -> busy.
        expect_out(e_c + 484, 12, 0, 0, 1);
        expect_out(e_c + 488, 12, 1, 0, 1);
        // 6 and 2 pulse windows hold K; then stop mid-window.
        expect_out(e_c + 525, 12, 0, 0, 0);
        // Restart, busy windows at K_MIN hold, quiet steps up, reset mid-settle.
        expect_out(s_c,      1, 0, 0, 1);
        expect_out(s_c + 4,  1, 1, 0, 1);
        expect_out(s_c + 52, 2, 0, 0, 1);
        expect_out(s_c + 54, 1, 0, 0, 0);

        bus.start = 1'b1;
        goto(e_c);
        bus.start = 1'b0;

        pulses(e_c + 317, 8, 1'b0);
        pulses(e_c + 390, 2, 1'b0);
        pulses(e_c + 450, 7, 1'b1);
        pulses(e_c + 470, 6, 1'b0);
        pulses(e_c + 484, 1, 1'b0);
        pulses(e_c + 490, 6, 1'b1);
        pulses(e_c + 506, 2, 1'b0);

        goto(e_c + 524);
        bus.stop  = 1'b1;
        goto(e_c + 525);
        bus.start = 1'b1;                   // start with stop: stays IDLE
        goto(e_c + 526);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        goto(s_c - 1);
        bus.start = 1'b1;
        goto(s_c);
        bus.start = 1'b0;

        pulses(s_c + 6, 10, 1'b0);
        pulses(s_c + 22, 10, 1'b1);

        goto(s_c + 53);
        reset = 1'b1;
        goto(s_c + 54);
        reset = 1'b0;

        goto(s_c + 80);
        @(negedge clk);
        #1;
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_change got none, required cyc %0d kMode=%0d en=%0b locked=%0b busy=%0b",
                     e.cyc, e.k, e.en, e.lk, e.bz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
